gen_mux_sel_seq_ctrl: RTL and testbench

Parametrised successor to the fixed 1-of-9 mux select generator. It holds a run-time programmable pattern LUT of LUT_ROWS rows by LUT_COLS columns. It sequences the select code for an NUM_IN:1 register mux, one column per accepted beat, with a valid/ready handshake to the consumer. It sits between the SR datapath control and the window/register-bank mux.

---
 rtl/gen_mux_sel_pkg.sv | 21 ++
 rtl/gen_mux_sel_lut.sv | 34 +++
 rtl/gen_mux_sel_seq_ctrl.sv | 119 +++++++++++
 tb/tb_gen_mux_sel_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_mux_sel_pkg.sv
// gen_mux_sel_pkg: shared state type, default pattern LUT contents and parameter legality checks
package gen_mux_sel_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int DEF_NUM_IN   = 9;
  localparam int DEF_SEL_W    = 4;
  localparam int DEF_LUT_ROWS = 4;
  localparam int DEF_ROW_W    = 2;
  localparam int DEF_LUT_COLS = 9;
  localparam int DEF_COL_W    = 4;
  function automatic int lut_default(int row, int col, int num_in, int lut_cols);
    return row == 1 ? (lut_cols - 1 - col) % num_in :
           row == 2 ? (col + 1) % num_in :
           row == 3 ? ((col % 3) * 3 + col / 3) % num_in :
                      col % num_in;
  endfunction
  function automatic bit params_ok(int num_in, int sel_w, int lut_rows, int row_w,
                                   int lut_cols, int col_w);
    return num_in > 0 && lut_rows > 0 && lut_cols > 0 &&
           (2 ** sel_w) >= num_in && (2 ** row_w) >= lut_rows && (2 ** col_w) > lut_cols;
  endfunction
endpackage

// File: rtl/gen_mux_sel_lut.sv
// gen_mux_sel_lut: pattern LUT register array with gated write port, reset defaults and write-through read
module gen_mux_sel_lut
  import gen_mux_sel_pkg::*;
#(
  parameter int NUM_IN   = DEF_NUM_IN,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int LUT_ROWS = DEF_LUT_ROWS,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int LUT_COLS = DEF_LUT_COLS,
  parameter int COL_W    = DEF_COL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [SEL_W-1:0] wr_data,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic [SEL_W-1:0] rd_data
);
  logic [SEL_W-1:0] lut_q [LUT_ROWS][LUT_COLS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < LUT_ROWS; r++)
        for (int c = 0; c < LUT_COLS; c++)
          lut_q[r][c] <= SEL_W'(lut_default(r, c, NUM_IN, LUT_COLS));
    end else if (wr_en) begin
      lut_q[wr_row][wr_col] <= wr_data;
    end
  end
  // Forwarding lets a write landing with START be seen by that run's first beat
  assign rd_data = (wr_en && wr_row == rd_row && wr_col == rd_col) ? wr_data : lut_q[rd_row][rd_col];
endmodule

// File: rtl/gen_mux_sel_seq_ctrl.sv
// gen_mux_sel_seq_ctrl: LUT-driven NUM_IN:1 mux select sequencer with valid/ready output; GEN_MUX_SEL_CONT_EN enables continuous passes
module gen_mux_sel_seq_ctrl
  import gen_mux_sel_pkg::*;
#(
  parameter int NUM_IN   = DEF_NUM_IN,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int LUT_ROWS = DEF_LUT_ROWS,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int LUT_COLS = DEF_LUT_COLS,
  parameter int COL_W    = DEF_COL_W
) (
  input  logic             SYS_CLK,
  input  logic             SYS_NRST,
  input  logic             START,
  input  logic             STOP,
  input  logic             CONT,
  input  logic [ROW_W-1:0] ROW_SEL,
  input  logic [COL_W-1:0] STEP_CNT,
  input  logic             DST_RDY,
  input  logic             LUT_WR_EN,
  input  logic [ROW_W-1:0] LUT_WR_ROW,
  input  logic [COL_W-1:0] LUT_WR_COL,
  input  logic [SEL_W-1:0] LUT_WR_DATA,
  output logic [SEL_W-1:0] CTRL_REGNUM_SEL,
  output logic             CTRL_VLD,
  output logic             BUSY,
  output logic             DONE,
  output logic             WR_ERR
);
  localparam bit PARAMS_OK = params_ok(NUM_IN, SEL_W, LUT_ROWS, ROW_W, LUT_COLS, COL_W);
  localparam logic [COL_W-1:0] COLS_L = COL_W'(LUT_COLS);
  if (!PARAMS_OK) begin : g_param_err
    $error("gen_mux_sel_seq_ctrl: illegal parameter set");
  end
  state_e           state_q;
  logic [ROW_W-1:0] row_q, row_d, rd_row;
  logic [COL_W-1:0] steps_q, steps_d, col_q, rd_col;
  logic [SEL_W-1:0] sel_q, rd_data;
  logic             vld_q, done_q, wr_err_q, wr_ok, last, cont;
`ifdef GEN_MUX_SEL_CONT_EN
  assign cont = CONT;
`else
  logic unused_cont;
  assign unused_cont = CONT;
  assign cont = 1'b0;
`endif
  assign row_d   = ({1'b0, ROW_SEL} < (ROW_W + 1)'(LUT_ROWS)) ? ROW_SEL : '0;
  assign steps_d = (STEP_CNT == '0 || STEP_CNT > COLS_L) ? COLS_L : STEP_CNT;
  assign last    = col_q == steps_q - 1'b1;
  assign wr_ok   = LUT_WR_EN && state_q == IDLE &&
                   {1'b0, LUT_WR_DATA} < (SEL_W + 1)'(NUM_IN) &&
                   {1'b0, LUT_WR_ROW} < (ROW_W + 1)'(LUT_ROWS) &&
                   {1'b0, LUT_WR_COL} < (COL_W + 1)'(LUT_COLS);
  // Read address is the value to present after the coming edge
  always_comb begin
    rd_row = row_q;
    rd_col = col_q + 1'b1;
    if (state_q == IDLE || (last && cont)) begin
      rd_row = row_d;
      rd_col = '0;
    end
  end
  gen_mux_sel_lut #(
    .NUM_IN(NUM_IN), .SEL_W(SEL_W), .LUT_ROWS(LUT_ROWS),
    .ROW_W(ROW_W), .LUT_COLS(LUT_COLS), .COL_W(COL_W)
  ) u_lut (
    .clk(SYS_CLK), .rst_n(SYS_NRST), .wr_en(wr_ok), .wr_row(LUT_WR_ROW),
    .wr_col(LUT_WR_COL), .wr_data(LUT_WR_DATA), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data)
  );
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q  <= IDLE;
      row_q    <= '0;
      steps_q  <= '0;
      col_q    <= '0;
      sel_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= LUT_WR_EN && !wr_ok;
      if (state_q == IDLE) begin
        if (START) begin
          state_q <= RUN;
          row_q   <= row_d;
          steps_q <= steps_d;
          col_q   <= '0;
          sel_q   <= rd_data;
          vld_q   <= 1'b1;
        end
      end else if (STOP) begin
        state_q <= IDLE;
        vld_q   <= 1'b0;
      end else if (vld_q && DST_RDY) begin
        if (!last) begin
          col_q <= col_q + 1'b1;
          sel_q <= rd_data;
        end else if (cont) begin
          done_q <= 1'b1;
          row_q  <= row_d;
          col_q  <= '0;
          sel_q  <= rd_data;
        end else begin
          done_q  <= 1'b1;
          state_q <= IDLE;
          col_q   <= '0;
          vld_q   <= 1'b0;
        end
      end
    end
  end
  assign CTRL_REGNUM_SEL = sel_q;
  assign CTRL_VLD        = vld_q;
  assign BUSY            = state_q == RUN;
  assign DONE            = done_q;
  assign WR_ERR          = wr_err_q;
endmodule

// File: tb/tb_gen_mux_sel_seq_ctrl.sv
// tb_gen_mux_sel_seq_ctrl: directed self-checking bench for the mux select sequencer
module tb_gen_mux_sel_seq_ctrl;
  logic       SYS_CLK = 1'b0;
  logic       SYS_NRST = 1'b1;
  logic       START = 1'b0, STOP = 1'b0, CONT = 1'b0, DST_RDY = 1'b0, LUT_WR_EN = 1'b0;
  logic [1:0] ROW_SEL = '0, LUT_WR_ROW = '0;
  logic [3:0] STEP_CNT = '0, LUT_WR_COL = '0, LUT_WR_DATA = '0;
  logic [3:0] CTRL_REGNUM_SEL;
  logic       CTRL_VLD, BUSY, DONE, WR_ERR;
  int         checks = 0, failures = 0;
  int         row3_seq[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

  gen_mux_sel_seq_ctrl dut (
    .SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST), .START(START), .STOP(STOP), .CONT(CONT),
    .ROW_SEL(ROW_SEL), .STEP_CNT(STEP_CNT), .DST_RDY(DST_RDY), .LUT_WR_EN(LUT_WR_EN),
    .LUT_WR_ROW(LUT_WR_ROW), .LUT_WR_COL(LUT_WR_COL), .LUT_WR_DATA(LUT_WR_DATA),
    .CTRL_REGNUM_SEL(CTRL_REGNUM_SEL), .CTRL_VLD(CTRL_VLD), .BUSY(BUSY), .DONE(DONE),
    .WR_ERR(WR_ERR)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] row, input logic [3:0] steps);
    ROW_SEL = row;
    STEP_CNT = steps;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    #2 SYS_NRST = 1'b0;
    #1;
    chk("rst_sel", CTRL_REGNUM_SEL, 0);
    chk("rst_vld", CTRL_VLD, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_wrerr", WR_ERR, 0);
    tick();
    SYS_NRST = 1'b1;
    tick();
    chk("idle_vld", CTRL_VLD, 0);

    DST_RDY = 1'b1;
    start_run(2'd0, 4'd9);
    chk("r0_busy", BUSY, 1);
    for (int i = 0; i < 9; i++) begin
      chk("r0_sel", CTRL_REGNUM_SEL, i);
      chk("r0_vld", CTRL_VLD, 1);
      chk("r0_nodone", DONE, 0);
      tick();
    end
    chk("r0_done", DONE, 1);
    chk("r0_vld_end", CTRL_VLD, 0);
    chk("r0_busy_end", BUSY, 0);
    chk("r0_sel_hold", CTRL_REGNUM_SEL, 8);
    tick();
    chk("r0_done_pulse", DONE, 0);

    start_run(2'd3, 4'd0);
    for (int i = 0; i < 9; i++) begin
      chk("r3_sel", CTRL_REGNUM_SEL, row3_seq[i]);
      tick();
    end
    chk("r3_done", DONE, 1);
    chk("r3_vld_end", CTRL_VLD, 0);

    DST_RDY = 1'b0;
    start_run(2'd1, 4'd9);
    for (int i = 0; i < 9; i++) begin
      chk("bp_sel", CTRL_REGNUM_SEL, 8 - i);
      tick();
      chk("bp_hold1", CTRL_REGNUM_SEL, 8 - i);
      chk("bp_vld1", CTRL_VLD, 1);
      tick();
      chk("bp_hold2", CTRL_REGNUM_SEL, 8 - i);
      DST_RDY = 1'b1;
      tick();
      DST_RDY = 1'b0;
    end
    chk("bp_done", DONE, 1);
    chk("bp_vld_end", CTRL_VLD, 0);

    DST_RDY = 1'b1;
    start_run(2'd0, 4'd9);
    tick(); tick(); tick(); tick();
    chk("stop_sel4", CTRL_REGNUM_SEL, 4);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("stop_vld", CTRL_VLD, 0);
    chk("stop_busy", BUSY, 0);
    chk("stop_nodone", DONE, 0);
    chk("stop_sel_hold", CTRL_REGNUM_SEL, 4);
    tick();
    chk("stop_nodone2", DONE, 0);
    chk("stop_idle_vld", CTRL_VLD, 0);
    start_run(2'd0, 4'd9);
    chk("restart_sel", CTRL_REGNUM_SEL, 0);
    tick();
    chk("restart_sel1", CTRL_REGNUM_SEL, 1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_in_run_ign", CTRL_REGNUM_SEL, 2);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("stop2_vld", CTRL_VLD, 0);

    START = 1'b1;
    STOP = 1'b1;
    ROW_SEL = 2'd2;
    STEP_CNT = 4'd1;
    tick();
    START = 1'b0;
    STOP = 1'b0;
    chk("startstop_vld", CTRL_VLD, 1);
    chk("startstop_sel", CTRL_REGNUM_SEL, 1);
    tick();
    chk("steps1_done", DONE, 1);
    chk("steps1_vld", CTRL_VLD, 0);

    LUT_WR_EN = 1'b1; LUT_WR_ROW = 2'd2; LUT_WR_COL = 4'd0; LUT_WR_DATA = 4'd5;
    tick();
    LUT_WR_EN = 1'b0;
    chk("wr_ok_noerr", WR_ERR, 0);
    start_run(2'd2, 4'd1);
    chk("wr_r2_sel", CTRL_REGNUM_SEL, 5);
    tick();
    chk("wr_r2_done", DONE, 1);

    LUT_WR_EN = 1'b1; LUT_WR_DATA = 4'd9;
    tick();
    LUT_WR_EN = 1'b0;
    chk("wr_bad_err", WR_ERR, 1);
    tick();
    chk("wr_err_pulse", WR_ERR, 0);
    LUT_WR_EN = 1'b1; LUT_WR_COL = 4'd9; LUT_WR_DATA = 4'd1;
    tick();
    LUT_WR_EN = 1'b0;
    chk("wr_badcol_err", WR_ERR, 1);
    start_run(2'd2, 4'd2);
    chk("wr_unchanged", CTRL_REGNUM_SEL, 5);
    tick();
    chk("wr_r2_col1", CTRL_REGNUM_SEL, 2);
    tick();

    DST_RDY = 1'b0;
    start_run(2'd0, 4'd2);
    LUT_WR_EN = 1'b1; LUT_WR_ROW = 2'd0; LUT_WR_COL = 4'd1; LUT_WR_DATA = 4'd7;
    tick();
    LUT_WR_EN = 1'b0;
    chk("wr_busy_err", WR_ERR, 1);
    chk("wr_busy_sel", CTRL_REGNUM_SEL, 0);
    DST_RDY = 1'b1;
    tick();
    chk("wr_busy_nochange", CTRL_REGNUM_SEL, 1);
    tick();
    chk("wr_busy_done", DONE, 1);

    LUT_WR_EN = 1'b1; LUT_WR_ROW = 2'd2; LUT_WR_COL = 4'd0; LUT_WR_DATA = 4'd3;
    start_run(2'd2, 4'd1);
    LUT_WR_EN = 1'b0;
    chk("wr_with_start", CTRL_REGNUM_SEL, 3);
    chk("wr_with_start_err", WR_ERR, 0);
    tick();

    start_run(2'd0, 4'd12);
    for (int i = 0; i < 9; i++) begin
      chk("big_steps_sel", CTRL_REGNUM_SEL, i);
      tick();
    end
    chk("big_steps_done", DONE, 1);

    CONT = 1'b1;
    start_run(2'd0, 4'd3);
`ifdef GEN_MUX_SEL_CONT_EN
    chk("cont_s0", CTRL_REGNUM_SEL, 0);
    tick();
    chk("cont_s1", CTRL_REGNUM_SEL, 1);
    ROW_SEL = 2'd1;
    tick();
    chk("cont_s2", CTRL_REGNUM_SEL, 2);
    chk("cont_nodone", DONE, 0);
    tick();
    chk("cont_wrap_sel", CTRL_REGNUM_SEL, 8);
    chk("cont_wrap_vld", CTRL_VLD, 1);
    chk("cont_done1", DONE, 1);
    tick();
    chk("cont_s7", CTRL_REGNUM_SEL, 7);
    chk("cont_done_pulse", DONE, 0);
    CONT = 1'b0;
    tick();
    chk("cont_s6", CTRL_REGNUM_SEL, 6);
    tick();
    chk("cont_done2", DONE, 1);
    chk("cont_end_vld", CTRL_VLD, 0);
`else
    tick(); tick(); tick();
    chk("nocont_done", DONE, 1);
    chk("nocont_vld", CTRL_VLD, 0);
    chk("nocont_busy", BUSY, 0);
    CONT = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
